// File: rtl/mod_cache_arbiter.sv
// Two-requester cache arbiter: grants the shared cache to one processor at a time,
// holds it for ACCESS_CYCLES cycles, then pulses that processor's Ack. Ties go round-robin.
module mod_cache_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic proc1_Req,
  input  logic proc2_Req,
  output logic sel,
  output logic cache_En,
  output logic proc1_Ack,
  output logic proc2_Ack,
  output logic busy
);

  // Handshake: a processor raises its Req and holds it until its Ack pulses for one cycle;
  // once granted, the access always runs to completion even if Req drops early.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic       en_q, en_d;
  logic       ack1_q, ack1_d;
  logic       ack2_q, ack2_d;
  logic       busy_q, busy_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       winner;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = 1'b0;
    ack1_d  = 1'b0;
    ack2_d  = 1'b0;
    cnt_d   = cnt_q;
    last_d  = last_q;
    winner  = 1'b0;
    case (state_q)
      IDLE: begin
        if (proc1_Req || proc2_Req) begin
          // On a tie the processor not served last wins (last_q: 0 = proc1, 1 = proc2).
          winner  = (proc1_Req && proc2_Req) ? ~last_q : proc2_Req;
          state_d = ACCESS;
          sel_d   = winner;
          en_d    = 1'b1;
          cnt_d   = CNT_LOAD;
        end
      end
      ACCESS: begin
        en_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = ACK;
          en_d    = 1'b0;
          ack1_d  = ~sel_q;
          ack2_d  = sel_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      en_q    <= 1'b0;
      ack1_q  <= 1'b0;
      ack2_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      ack1_q  <= ack1_d;
      ack2_q  <= ack2_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign sel       = sel_q;
  assign cache_En  = en_q;
  assign proc1_Ack = ack1_q;
  assign proc2_Ack = ack2_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mod_cache_arbiter.sv
// Directed bench for mod_cache_arbiter: three instances (ACCESS_CYCLES = 2, 1, 15).
// Output vectors are packed as {sel, cache_En, proc1_Ack, proc2_Ack, busy}.
module tb_mod_cache_arbiter;

  logic clk;
  logic rst;
  logic p1, p2, q1, q15;
  logic sel_a, en_a, a1_a, a2_a, busy_a;
  logic sel_b, en_b, a1_b, a2_b, busy_b;
  logic sel_c, en_c, a1_c, a2_c, busy_c;
  logic [4:0] v2, v1, v15;
  logic [4:0] exp_q[$];
  logic [4:0] exp_v;
  int n_total;
  int n_bad;

  mod_cache_arbiter #(.ACCESS_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .proc1_Req(p1), .proc2_Req(p2),
    .sel(sel_a), .cache_En(en_a), .proc1_Ack(a1_a), .proc2_Ack(a2_a), .busy(busy_a)
  );

  mod_cache_arbiter #(.ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .proc1_Req(q1), .proc2_Req(1'b0),
    .sel(sel_b), .cache_En(en_b), .proc1_Ack(a1_b), .proc2_Ack(a2_b), .busy(busy_b)
  );

  mod_cache_arbiter #(.ACCESS_CYCLES(15)) dut15 (
    .clk(clk), .rst(rst), .proc1_Req(q15), .proc2_Req(1'b0),
    .sel(sel_c), .cache_En(en_c), .proc1_Ack(a1_c), .proc2_Ack(a2_c), .busy(busy_c)
  );

  assign v2  = {sel_a, en_a, a1_a, a2_a, busy_a};
  assign v1  = {sel_b, en_b, a1_b, a2_b, busy_b};
  assign v15 = {sel_c, en_c, a1_c, a2_c, busy_c};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  // one granted access on the ACCESS_CYCLES=2 instance: two enable cycles, then the Ack cycle
  task automatic run_txn(input string tag, input logic w);
    for (int i = 0; i < 2; i++) begin
      step();
      chk(tag, v2, {w, 1'b1, 1'b0, 1'b0, 1'b1});
    end
    step();
    chk(tag, v2, {w, 1'b0, ~w, w, 1'b1});
  endtask

  initial begin
    n_total = 0;
    n_bad = 0;
    rst = 1'b1; p1 = 1'b0; p2 = 1'b0; q1 = 1'b0; q15 = 1'b0;
    step();
    step();
    chk("reset_a", v2, 5'b00000);
    chk("reset_b", v1, 5'b00000);
    chk("reset_c", v15, 5'b00000);
    rst = 1'b0;
    step();
    chk("idle_noreq", v2, 5'b00000);

    // single proc1 request
    p1 = 1'b1;
    run_txn("single_p1", 1'b0);
    p1 = 1'b0;
    step();
    chk("single_p1_idle", v2, 5'b00000);

    // both held: proc1 served last, so proc2 leads, then strict alternation
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 0) ? 5'b1 : 5'b0);
    p1 = 1'b1; p2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_v = exp_q.pop_front();
      run_txn("rr_grant", exp_v[0]);
      if (i == 7) begin
        p1 = 1'b0; p2 = 1'b0;
      end
      step();
      chk("rr_idle", v2, {exp_v[0], 4'b0000});
    end

    // proc2 in progress, proc1 arrives mid-access and waits
    p2 = 1'b1;
    step();
    chk("mid_p2_a", v2, 5'b11001);
    p1 = 1'b1;
    step();
    chk("mid_p2_b", v2, 5'b11001);
    step();
    chk("mid_p2_ack", v2, 5'b10011);
    p2 = 1'b0;
    step();
    chk("mid_idle", v2, 5'b10000);
    run_txn("mid_p1", 1'b0);
    p1 = 1'b0;
    step();
    chk("mid_p1_idle", v2, 5'b00000);

    // request dropped during access still completes
    p1 = 1'b1;
    step();
    chk("drop_a", v2, 5'b01001);
    p1 = 1'b0;
    step();
    chk("drop_b", v2, 5'b01001);
    step();
    chk("drop_ack", v2, 5'b00101);
    step();
    chk("drop_idle", v2, 5'b00000);

    // reset in the middle of a proc2 access
    p2 = 1'b1;
    step();
    chk("rst_pre", v2, 5'b11001);
    rst = 1'b1;
    p1 = 1'b1;
    step();
    chk("rst_abort", v2, 5'b00000);
    step();
    chk("rst_hold", v2, 5'b00000);
    rst = 1'b0;
    run_txn("rst_first_p1", 1'b0);
    p1 = 1'b0;
    step();
    chk("rst_idle", v2, 5'b00000);
    run_txn("rst_then_p2", 1'b1);
    p2 = 1'b0;
    step();
    chk("rst_p2_idle", v2, 5'b10000);

    // ACCESS_CYCLES = 1
    q1 = 1'b1;
    step();
    chk("ac1_en", v1, 5'b01001);
    step();
    chk("ac1_ack", v1, 5'b00101);
    q1 = 1'b0;
    step();
    chk("ac1_idle", v1, 5'b00000);

    // ACCESS_CYCLES = 15
    q15 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("ac15_en", v15, 5'b01001);
    end
    step();
    chk("ac15_ack", v15, 5'b00101);
    q15 = 1'b0;
    step();
    chk("ac15_idle", v15, 5'b00000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
